// File: rtl/pcim_write_arbiter.sv
// pcim_write_arbiter: shares the PCIM AXI4 write path between two requesters with
// round-robin AW grants, order-FIFO W steering and ID-routed B responses.
module pcim_write_arbiter #(
  parameter int id_width_p        = 6,
  parameter int addr_width_p      = 64,
  parameter int data_width_p      = 512,
  parameter int max_outstanding_p = 4
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [1:0][id_width_p-2:0]           s_awid_i,
  input  logic [1:0][addr_width_p-1:0]         s_awaddr_i,
  input  logic [1:0][7:0]                      s_awlen_i,
  input  logic [1:0][2:0]                      s_awsize_i,
  input  logic [1:0]                           s_awvalid_i,
  output logic [1:0]                           s_awready_o,
  input  logic [1:0][data_width_p-1:0]         s_wdata_i,
  input  logic [1:0][data_width_p/8-1:0]       s_wstrb_i,
  input  logic [1:0]                           s_wlast_i,
  input  logic [1:0]                           s_wvalid_i,
  output logic [1:0]                           s_wready_o,
  output logic [1:0][id_width_p-2:0]           s_bid_o,
  output logic [1:0][1:0]                      s_bresp_o,
  output logic [1:0]                           s_bvalid_o,
  input  logic [1:0]                           s_bready_i,
  output logic [id_width_p-1:0]                m_awid_o,
  output logic [addr_width_p-1:0]              m_awaddr_o,
  output logic [7:0]                           m_awlen_o,
  output logic [2:0]                           m_awsize_o,
  output logic                                 m_awvalid_o,
  input  logic                                 m_awready_i,
  output logic [data_width_p-1:0]              m_wdata_o,
  output logic [data_width_p/8-1:0]            m_wstrb_o,
  output logic                                 m_wlast_o,
  output logic                                 m_wvalid_o,
  input  logic                                 m_wready_i,
  input  logic [id_width_p-1:0]                m_bid_i,
  input  logic [1:0]                           m_bresp_i,
  input  logic                                 m_bvalid_i,
  output logic                                 m_bready_o
);
  localparam int cw = $clog2(max_outstanding_p + 1);
  localparam int pw = max_outstanding_p > 1 ? $clog2(max_outstanding_p) : 1;
  localparam logic [cw-1:0] max_c = cw'(max_outstanding_p);
  localparam logic [pw-1:0] last_p = pw'(max_outstanding_p - 1);
  typedef enum logic {EMPTY, FULL} state_e;
  state_e state, state_n;
  logic last_grant, winner, grant, head, pop, b_port, b_fire, fifo_full, fifo_empty;
  logic [max_outstanding_p-1:0] fifo_q;
  logic [pw-1:0] rd_ptr, wr_ptr;
  logic [cw-1:0] fifo_cnt, outstanding;
  assign fifo_full  = fifo_cnt == max_c;
  assign fifo_empty = fifo_cnt == '0;
  assign winner = s_awvalid_i[~last_grant] ? ~last_grant : last_grant;
  assign grant = !reset_i && state == EMPTY && |s_awvalid_i && !fifo_full && outstanding < max_c;
  assign s_awready_o = grant ? 2'b01 << winner : 2'b00;
  assign m_awvalid_o = state == FULL;
  always_comb state_n = state == EMPTY ? (grant ? FULL : EMPTY) : (m_awready_i ? EMPTY : FULL);
  assign head       = fifo_q[rd_ptr];
  assign m_wvalid_o = !fifo_empty && s_wvalid_i[head];
  assign m_wdata_o  = s_wdata_i[head];
  assign m_wstrb_o  = s_wstrb_i[head];
  assign m_wlast_o  = s_wlast_i[head];
  assign s_wready_o = (!fifo_empty && m_wready_i) ? 2'b01 << head : 2'b00;
  assign pop        = m_wvalid_o && m_wready_i && m_wlast_o;
  assign b_port     = m_bid_i[id_width_p-1];
  assign s_bvalid_o = m_bvalid_i ? (b_port ? 2'b10 : 2'b01) : 2'b00;
  assign m_bready_o = s_bready_i[b_port];
  assign b_fire     = m_bvalid_i && m_bready_o;
  always_comb begin
    s_bid_o = '0;
    s_bresp_o = '0;
    s_bid_o[b_port] = m_bid_i[id_width_p-2:0];
    s_bresp_o[b_port] = m_bresp_i;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= EMPTY;
      last_grant  <= 1'b1;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
    end else begin
      state       <= state_n;
      fifo_cnt    <= fifo_cnt + cw'(grant) - cw'(pop);
      outstanding <= outstanding + cw'(grant) - cw'(b_fire);
      if (grant) last_grant <= winner;
      if (grant) wr_ptr <= wr_ptr == last_p ? '0 : wr_ptr + pw'(1);
      if (pop) rd_ptr <= rd_ptr == last_p ? '0 : rd_ptr + pw'(1);
    end
  end
  // Payload registers need no reset: m_awvalid_o alone qualifies them.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      fifo_q[wr_ptr] <= winner;
      m_awid_o       <= {winner, s_awid_i[winner]};
      m_awaddr_o     <= s_awaddr_i[winner];
      m_awlen_o      <= s_awlen_i[winner];
      m_awsize_o     <= s_awsize_i[winner];
    end
  end
`ifndef SYNTHESIS
  logic aw_hold;
  always_ff @(posedge clk_i) begin
    aw_hold <= !reset_i && m_awvalid_o && !m_awready_i;
    if (!reset_i) begin
      assert (!(b_fire && outstanding == '0)) else $error("B handshake with nothing outstanding");
      assert (!aw_hold || m_awvalid_o) else $error("m_awvalid_o dropped without m_awready_i");
    end
  end
`endif
endmodule

// File: tb/tb_pcim_write_arbiter.sv
// tb_pcim_write_arbiter: directed test-plan scenarios plus randomized traffic, all
// checked every cycle against a queue-based model of the arbiter.
module tb_pcim_write_arbiter;
  localparam int I = 6, A = 64, D = 512, S = D / 8, M = 4;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  logic [1:0][I-2:0] s_awid;
  logic [1:0][A-1:0] s_awaddr;
  logic [1:0][7:0] s_awlen;
  logic [1:0][2:0] s_awsize;
  logic [1:0] s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [1:0][D-1:0] s_wdata;
  logic [1:0][S-1:0] s_wstrb;
  logic [1:0][I-2:0] s_bid;
  logic [1:0][1:0] s_bresp;
  logic [I-1:0] m_awid, m_bid;
  logic [A-1:0] m_awaddr;
  logic [7:0] m_awlen;
  logic [2:0] m_awsize;
  logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [D-1:0] m_wdata;
  logic [S-1:0] m_wstrb;
  logic [1:0] m_bresp;
  pcim_write_arbiter dut (
    .clk_i(clk), .reset_i(rst),
    .s_awid_i(s_awid), .s_awaddr_i(s_awaddr), .s_awlen_i(s_awlen), .s_awsize_i(s_awsize),
    .s_awvalid_i(s_awvalid), .s_awready_o(s_awready),
    .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb), .s_wlast_i(s_wlast), .s_wvalid_i(s_wvalid),
    .s_wready_o(s_wready),
    .s_bid_o(s_bid), .s_bresp_o(s_bresp), .s_bvalid_o(s_bvalid), .s_bready_i(s_bready),
    .m_awid_o(m_awid), .m_awaddr_o(m_awaddr), .m_awlen_o(m_awlen), .m_awsize_o(m_awsize),
    .m_awvalid_o(m_awvalid), .m_awready_i(m_awready),
    .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_wlast_o(m_wlast), .m_wvalid_o(m_wvalid),
    .m_wready_i(m_wready),
    .m_bid_i(m_bid), .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready)
  );
  int vectors = 0, miscompares = 0;
  task automatic chk(input string n, input logic [D-1:0] act, input logic [D-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  // Model: a one-entry AW slot, an order queue of ports, a count of open bursts.
  typedef struct packed {logic [I-1:0] id; logic [A-1:0] addr; logic [7:0] len; logic [2:0] size;} aw_t;
  aw_t slot[$];
  int order[$];
  int last_g = 1, outst = 0;
  bit live = 0;
  always @(negedge clk) begin : model
    bit g, wfire, bfire;
    int w, h, p;
    g = !rst && slot.size() == 0 && s_awvalid != 2'b00 && order.size() < M && outst < M;
    w = s_awvalid[1-last_g] ? 1 - last_g : last_g;
    h = order.size() ? order[0] : 0;
    p = int'(m_bid[I-1]);
    wfire = order.size() != 0 && s_wvalid[h] && m_wready;
    bfire = m_bvalid && s_bready[p];
    if (live) begin
      chk("awvalid", m_awvalid, slot.size() != 0);
      if (slot.size()) chk("aw_fields", {m_awid, m_awaddr, m_awlen, m_awsize}, slot[0]);
      chk("s_awready", s_awready, g ? 2'(1 << w) : 2'b00);
      if (order.size()) begin
        chk("m_wvalid", m_wvalid, s_wvalid[h]);
        chk("m_wdata", m_wdata, s_wdata[h]);
        chk("m_wstrb_wlast", {m_wstrb, m_wlast}, {s_wstrb[h], s_wlast[h]});
        chk("s_wready", s_wready, m_wready ? 2'(1 << h) : 2'b00);
      end else chk("w_idle", {m_wvalid, s_wready}, 3'b000);
      chk("s_bvalid", s_bvalid, m_bvalid ? 2'(1 << p) : 2'b00);
      chk("m_bready", m_bready, s_bready[p]);
      if (m_bvalid) chk("b_fields", {s_bid[p], s_bresp[p]}, {m_bid[I-2:0], m_bresp});
    end
    if (rst) begin
      slot.delete(); order.delete(); last_g = 1; outst = 0; live = 1;
    end else begin
      if (slot.size() && m_awready) void'(slot.pop_front());
      if (wfire && s_wlast[h]) void'(order.pop_front());
      if (g) begin
        slot.push_back({1'(w), s_awid[w], s_awaddr[w], s_awlen[w], s_awsize[w]});
        order.push_back(w); outst++; last_g = w;
      end
      if (bfire) outst--;
    end
  end
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic nc(); @(negedge clk); endtask
  task automatic idle();
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awvalid = '0;
    s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
    m_awready = 0; m_wready = 0; m_bid = '0; m_bresp = '0; m_bvalid = 0;
  endtask
  task automatic do_reset();
    tick(); idle(); rst = 1; tick(); tick(); rst = 0;
  endtask
  initial begin
    int n;
    idle(); rst = 1;
    s_awvalid = 2'b11;
    tick(); tick(); nc();
    chk("rst_awvalid", m_awvalid, 1'b0);
    chk("rst_awready", s_awready, 2'b00);
    // Port 0 alone, 4-beat burst
    tick(); rst = 0; s_awvalid = 2'b01; s_awid[0] = 5'd5; s_awlen[0] = 8'd3;
    s_awaddr[0] = 64'h1000; m_awready = 1; m_wready = 1; nc();
    chk("p0_grant", s_awready, 2'b01);
    tick(); s_awvalid = 0; nc();
    chk("p0_awid", {m_awvalid, m_awid}, {1'b1, 6'h05});
    for (int b = 0; b < 4; b++) begin
      tick(); s_wvalid = 2'b01; s_wdata[0] = D'(b + 100); s_wlast = (b == 3) ? 2'b01 : 2'b00; nc();
      chk("p0_wbeat", {m_wvalid, m_wlast, s_wready}, {1'b1, b == 3, 2'b01});
    end
    tick(); s_wvalid = 0; s_wlast = 0; m_bvalid = 1; m_bid = 6'h05; s_bready = 2'b01; nc();
    chk("p0_b", {s_bvalid, s_bid[0], m_bready}, {2'b01, 5'h05, 1'b1});
    tick(); m_bvalid = 0; nc();
    // Alternating grants
    do_reset(); s_awvalid = 2'b11; m_awready = 1; n = 0;
    for (int c = 0; c < 8; c++) begin
      nc();
      chk("rr_grant", s_awready, c % 2 ? 2'b00 : (c % 4 ? 2'b10 : 2'b01));
      tick();
    end
    s_awvalid = 0; s_wvalid = 2'b11; m_wready = 1; nc();
    chk("rr_w_head0", s_wready, 2'b01);
    tick(); s_wlast = 2'b11; nc();
    chk("rr_w_head0_last", s_wready, 2'b01);
    tick(); nc();
    chk("rr_w_head1", s_wready, 2'b10);
    // Outstanding limit
    do_reset(); s_awvalid = 2'b10; m_awready = 1; m_wready = 1; s_wvalid = 2'b10; s_wlast = 2'b10;
    for (int c = 0; c < 12; c++) begin
      nc(); if (s_awready[1]) n++; tick();
    end
    chk("limit_count", 32'(n), 32'd4);
    m_bvalid = 1; m_bid = 6'h20; s_bready = 2'b10; nc();
    chk("limit_blocked", s_awready, 2'b00);
    tick(); m_bvalid = 0; nc();
    chk("limit_fifth", s_awready, 2'b10);
    // AW stall
    do_reset(); s_awvalid = 2'b01; s_awid[0] = 5'h11; s_awaddr[0] = 64'hdead_beef; nc();
    tick(); s_awvalid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      nc();
      chk("stall_aw", {m_awvalid, m_awid, m_awaddr, s_awready}, {1'b1, 6'h11, 64'hdead_beef, 2'b00});
      tick();
    end
    // B back-pressure on port 1
    s_awvalid = 0; m_awready = 1; m_bvalid = 1; m_bid = 6'h2A; m_bresp = 2'b10; s_bready = 2'b01;
    for (int c = 0; c < 3; c++) begin
      nc();
      chk("b_hold", {m_bready, s_bvalid, s_bid[1], s_bresp[1]}, {1'b0, 2'b10, 5'h0A, 2'b10});
      tick();
    end
    s_bready = 2'b10; nc();
    chk("b_release", m_bready, 1'b1);
    tick(); m_bvalid = 0;
    // Reset mid-burst
    do_reset(); s_awvalid = 2'b01; s_awlen[0] = 8'd3; m_awready = 1; m_wready = 1; nc();
    tick(); s_awvalid = 0; s_wvalid = 2'b11; nc();
    tick(); nc();
    tick(); rst = 1; nc();
    tick(); rst = 0; nc();
    chk("midrst_out", {m_awvalid, m_wvalid, s_wready}, 4'b0000);
    tick(); s_awvalid = 2'b11; s_wvalid = 0; nc();
    chk("midrst_grant", s_awready, 2'b01);
    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst = $urandom_range(0, 199) == 0;
      for (int p = 0; p < 2; p++) begin
        s_awid[p] = 5'($urandom); s_awaddr[p] = {$urandom, $urandom};
        s_awlen[p] = 8'($urandom); s_awsize[p] = 3'($urandom);
        for (int k = 0; k < D / 32; k++) s_wdata[p][k*32 +: 32] = $urandom;
        s_wstrb[p] = {$urandom, $urandom};
      end
      s_awvalid = 2'($urandom); s_wvalid = 2'($urandom); s_wlast = 2'($urandom);
      s_bready = 2'($urandom);
      m_awready = $urandom_range(0, 9) < 7; m_wready = $urandom_range(0, 9) < 7;
      m_bid = 6'($urandom); m_bresp = 2'($urandom);
      m_bvalid = outst > 0 && $urandom_range(0, 2) == 0;
    end
    tick(); idle(); nc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
